// File: rtl/alu_accum_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_accum_seq
//  Description : Accumulator ALU with an OFF/READY/RUN/MULT/ERROR state
//                machine, unsigned overflow detection with optional
//                saturation, and a WIDTH-cycle shift-add multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_accum_seq #(
    parameter int WIDTH = 8,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             on,
    input  logic [1:0]       in_sel,
    input  logic [2:0]       op,
    input  logic             op_valid,
    input  logic [WIDTH-1:0] num_a,
    input  logic [WIDTH-1:0] num_b,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       state
);

    localparam logic [2:0] ST_OFF   = 3'd0;
    localparam logic [2:0] ST_READY = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_MULT  = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    localparam int              CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   C_LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] C_ONES   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] C_ZERO   = {WIDTH{1'b0}};

    logic [2:0]         state_q,  state_d;
    logic [WIDTH-1:0]   acc_q,    acc_d;
    logic               done_q,   done_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q,   prod_d;
    logic [CW-1:0]      cnt_q,    cnt_d;

    logic [WIDTH-1:0]   w_a;
    logic               w_accept;
    logic               w_soft_clr;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_ov;
    logic [2*WIDTH-1:0] w_prod_step;
    logic               w_mul_ov;

    // Operand A selection and request qualification
    always_comb begin
        case (in_sel)
            2'b01:   w_a = num_a;
            2'b10:   w_a = C_ZERO;
            default: w_a = acc_q;
        endcase
        w_soft_clr = (in_sel == 2'b10) && !op_valid && (state_q != ST_OFF);
        case (state_q)
            ST_READY:        w_accept = op_valid && ((in_sel == 2'b01) || (in_sel == 2'b10));
            ST_RUN, ST_ERROR: w_accept = op_valid;
            default:         w_accept = 1'b0;
        endcase
    end

    // Single-cycle ALU result with unsigned overflow and optional saturation
    always_comb begin
        w_sum     = {1'b0, w_a} + {1'b0, num_b};
        w_alu_res = C_ZERO;
        w_alu_ov  = 1'b0;
        case (op)
            OP_AND:  w_alu_res = w_a & num_b;
            OP_OR:   w_alu_res = w_a | num_b;
            OP_XOR:  w_alu_res = w_a ^ num_b;
            OP_NOT:  w_alu_res = ~w_a;
            OP_ADD: begin
                w_alu_ov  = w_sum[WIDTH];
                w_alu_res = (w_alu_ov && (SAT != 0)) ? C_ONES : w_sum[WIDTH-1:0];
            end
            OP_SUB: begin
                w_alu_ov  = (w_a < num_b);
                w_alu_res = (w_alu_ov && (SAT != 0)) ? C_ZERO : (w_a - num_b);
            end
            OP_PASS: w_alu_res = num_b;
            default: w_alu_res = C_ZERO;
        endcase
    end

    // One shift-add multiply step; the last step's sum is the final product
    always_comb begin
        w_prod_step = prod_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
        w_mul_ov    = |w_prod_step[2*WIDTH-1:WIDTH];
    end

    // Next-state logic: power-off beats soft clear, which beats MULT stepping and new requests
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        done_d   = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;

        if (!on) begin
            state_d = ST_OFF;
            acc_d   = C_ZERO;
            cnt_d   = '0;
        end else if (state_q == ST_OFF) begin
            state_d = ST_READY;
        end else if (w_soft_clr) begin
            state_d = ST_READY;
            acc_d   = C_ZERO;
            cnt_d   = '0;
        end else if (state_q == ST_MULT) begin
            prod_d   = w_prod_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == C_LAST) begin
                acc_d   = (w_mul_ov && (SAT != 0)) ? C_ONES : w_prod_step[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = w_mul_ov ? ST_ERROR : ST_RUN;
                cnt_d   = '0;
            end
        end else if (w_accept) begin
            if (op == OP_MUL) begin
                state_d  = ST_MULT;
                mcand_d  = {C_ZERO, w_a};
                mplier_d = num_b;
                prod_d   = {(2*WIDTH){1'b0}};
                cnt_d    = '0;
            end else begin
                acc_d   = w_alu_res;
                done_d  = 1'b1;
                state_d = w_alu_ov ? ST_ERROR : ST_RUN;
            end
        end
    end

    // State, accumulator and multiplier registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_OFF;
            acc_q    <= C_ZERO;
            done_q   <= 1'b0;
            mcand_q  <= {(2*WIDTH){1'b0}};
            mplier_q <= C_ZERO;
            prod_q   <= {(2*WIDTH){1'b0}};
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result = acc_q;
    assign busy   = (state_q == ST_MULT);
    assign done   = done_q;
    assign err    = (state_q == ST_ERROR);
    assign state  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_accum_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_accum_seq
//  Description : Directed bench driving a wrap (SAT=0) and a saturating
//                (SAT=1) accumulator ALU with identical stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_accum_seq;

    logic       clk;
    logic       rst;
    logic       on;
    logic [1:0] in_sel;
    logic [2:0] op;
    logic       op_valid;
    logic [7:0] num_a;
    logic [7:0] num_b;

    logic [7:0] result_w, result_s;
    logic       busy_w, busy_s;
    logic       done_w, done_s;
    logic       err_w, err_s;
    logic [2:0] state_w, state_s;

    int n_checks = 0;
    int n_fail   = 0;

    alu_accum_seq #(.WIDTH(8), .SAT(0)) u_dut_wrap (
        .clk(clk), .rst(rst), .on(on), .in_sel(in_sel), .op(op),
        .op_valid(op_valid), .num_a(num_a), .num_b(num_b),
        .result(result_w), .busy(busy_w), .done(done_w), .err(err_w),
        .state(state_w)
    );

    alu_accum_seq #(.WIDTH(8), .SAT(1)) u_dut_sat (
        .clk(clk), .rst(rst), .on(on), .in_sel(in_sel), .op(op),
        .op_valid(op_valid), .num_a(num_a), .num_b(num_b),
        .result(result_s), .busy(busy_s), .done(done_s), .err(err_s),
        .state(state_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the full output set of one instance
    task automatic chk_all(input string tag, input logic [7:0] res, input logic bsy,
                           input logic dn, input logic er, input logic [2:0] st,
                           input logic [7:0] e_res, input logic e_bsy, input logic e_dn,
                           input logic e_er, input logic [2:0] e_st);
        chk({tag, ".result"}, res, e_res);
        chk({tag, ".busy"}, {7'd0, bsy}, {7'd0, e_bsy});
        chk({tag, ".done"}, {7'd0, dn}, {7'd0, e_dn});
        chk({tag, ".err"}, {7'd0, er}, {7'd0, e_er});
        chk({tag, ".state"}, {5'd0, st}, {5'd0, e_st});
    endtask

    task automatic issue(input logic [1:0] sel, input logic [2:0] o,
                         input logic [7:0] a, input logic [7:0] b);
        in_sel   = sel;
        op       = o;
        num_a    = a;
        num_b    = b;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        in_sel   = 2'b00;
    endtask

    initial begin
        rst = 1'b1; on = 1'b0; in_sel = 2'b00; op = 3'b000;
        op_valid = 1'b0; num_a = 8'h00; num_b = 8'h00;
        tick();
        tick();
        chk_all("reset_w", result_w, busy_w, done_w, err_w, state_w, 8'h00, 0, 0, 0, 3'd0);
        chk_all("reset_s", result_s, busy_s, done_s, err_s, state_s, 8'h00, 0, 0, 0, 3'd0);

        // Power up: OFF -> READY
        rst = 1'b0; on = 1'b1;
        tick();
        chk("powerup.state", {5'd0, state_w}, 8'h01);

        // Load 0x0C + 0x0A
        issue(2'b01, 3'b100, 8'h0C, 8'h0A);
        chk_all("add_w", result_w, busy_w, done_w, err_w, state_w, 8'h16, 0, 1, 0, 3'd2);
        tick();
        chk("add.done_pulse", {7'd0, done_w}, 8'h00);

        // Accumulator = 0xF0 via PASS B, exact fit ADD boundary then overflow
        issue(2'b00, 3'b111, 8'h00, 8'hF0);
        chk("pass.result", result_w, 8'hF0);
        issue(2'b01, 3'b100, 8'hF0, 8'h0F);
        chk_all("add_fit_w", result_w, busy_w, done_w, err_w, state_w, 8'hFF, 0, 1, 0, 3'd2);
        issue(2'b00, 3'b111, 8'h00, 8'hF0);
        issue(2'b00, 3'b100, 8'h00, 8'h20);
        chk_all("add_ov_w", result_w, busy_w, done_w, err_w, state_w, 8'h10, 0, 1, 1, 3'd4);
        chk_all("add_ov_s", result_s, busy_s, done_s, err_s, state_s, 8'hFF, 0, 1, 1, 3'd4);
        issue(2'b00, 3'b000, 8'h00, 8'hFF);
        chk_all("and_clr_w", result_w, busy_w, done_w, err_w, state_w, 8'h10, 0, 1, 0, 3'd2);
        chk_all("and_clr_s", result_s, busy_s, done_s, err_s, state_s, 8'hFF, 0, 1, 0, 3'd2);

        // Logic ops and NOT A
        issue(2'b01, 3'b001, 8'hA0, 8'h05);
        chk("or.result", result_w, 8'hA5);
        issue(2'b00, 3'b010, 8'h00, 8'hFF);
        chk("xor.result", result_w, 8'h5A);
        issue(2'b00, 3'b011, 8'h00, 8'h33);
        chk("not.result", result_w, 8'hA5);

        // 0x0F * 0x0D = 0xC3 over 8 cycles, requests during busy ignored
        issue(2'b01, 3'b110, 8'h0F, 8'h0D);
        chk_all("mul_start_w", result_w, busy_w, done_w, err_w, state_w, 8'hA5, 1, 0, 0, 3'd3);
        for (int i = 1; i < 8; i++) begin
            if (i >= 2 && i <= 4) begin
                in_sel = 2'b01; op = 3'b111; num_b = 8'h55; op_valid = 1'b1;
            end else begin
                op_valid = 1'b0; in_sel = 2'b00;
            end
            tick();
            chk("mul_busy.busy", {7'd0, busy_w}, 8'h01);
            chk("mul_busy.done", {7'd0, done_w}, 8'h00);
        end
        op_valid = 1'b0; in_sel = 2'b00;
        tick();
        chk_all("mul_done_w", result_w, busy_w, done_w, err_w, state_w, 8'hC3, 0, 1, 0, 3'd2);
        tick();
        chk("mul.done_pulse", {7'd0, done_w}, 8'h00);

        // 0x20 * 0x10 = 0x200 overflows
        issue(2'b01, 3'b110, 8'h20, 8'h10);
        for (int i = 1; i < 8; i++) tick();
        tick();
        chk_all("mul_ov_w", result_w, busy_w, done_w, err_w, state_w, 8'h00, 0, 1, 1, 3'd4);
        chk_all("mul_ov_s", result_s, busy_s, done_s, err_s, state_s, 8'hFF, 0, 1, 1, 3'd4);

        // 0x05 - 0x07 borrows, accepted from ERROR
        issue(2'b01, 3'b101, 8'h05, 8'h07);
        chk_all("sub_ov_w", result_w, busy_w, done_w, err_w, state_w, 8'hFE, 0, 1, 1, 3'd4);
        chk_all("sub_ov_s", result_s, busy_s, done_s, err_s, state_s, 8'h00, 0, 1, 1, 3'd4);

        // Soft clear from ERROR
        in_sel = 2'b10; op_valid = 1'b0;
        tick();
        in_sel = 2'b00;
        chk_all("soft_clr_w", result_w, busy_w, done_w, err_w, state_w, 8'h00, 0, 0, 0, 3'd1);

        // Persist request in READY is ignored
        issue(2'b00, 3'b111, 8'h00, 8'h33);
        chk_all("ready_persist_w", result_w, busy_w, done_w, err_w, state_w, 8'h00, 0, 0, 0, 3'd1);

        // Power off during a multiply
        issue(2'b01, 3'b110, 8'h0F, 8'h0D);
        tick();
        tick();
        on = 1'b0;
        tick();
        chk_all("off_mul_w", result_w, busy_w, done_w, err_w, state_w, 8'h00, 0, 0, 0, 3'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("off.no_done", {7'd0, done_w}, 8'h00);
        end

        // Async reset mid-multiply
        on = 1'b1;
        tick();
        issue(2'b01, 3'b110, 8'h0F, 8'h0D);
        tick();
        chk("pre_rst.busy", {7'd0, busy_w}, 8'h01);
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst_w", result_w, busy_w, done_w, err_w, state_w, 8'h00, 0, 0, 0, 3'd0);
        chk_all("async_rst_s", result_s, busy_s, done_s, err_s, state_s, 8'h00, 0, 0, 0, 3'd0);
        tick();
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
